// File: rtl/kmeans_k2n5_centroid_update.sv
// Centroid update stage for k=2, 5-dimension k-means: accumulates per-centroid
// sums and counts over a pass, then divides them sequentially into new centroids.
module kmeans_k2n5_centroid_update #(
  parameter int unsigned input_data_width         = 8,
  parameter int unsigned input_data_qty_bit_width = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic                            selected_centroid,
  input  logic [input_data_width-1:0]     data0,
  input  logic [input_data_width-1:0]     data1,
  input  logic [input_data_width-1:0]     data2,
  input  logic [input_data_width-1:0]     data3,
  input  logic [input_data_width-1:0]     data4,
  input  logic [10*input_data_width-1:0]  cur_centroids,
  output logic [10*input_data_width-1:0]  new_centroids,
  output logic                            busy,
  output logic                            done,
  output logic                            converged
);

  localparam int unsigned W  = input_data_width;
  localparam int unsigned Q  = input_data_qty_bit_width;
  localparam int unsigned SW = W + Q;
  localparam int unsigned CW = Q + 1;
  localparam int unsigned RW = Q + 2;
  localparam int unsigned IW = $clog2(SW + 1);

  typedef enum logic [1:0] {IDLE, ACC, DIV, DONE} state_t;

  state_t state_q, state_d;

  logic [9:0][SW-1:0] sum_q;
  logic [1:0][CW-1:0] cnt_q;
  logic [9:0][W-1:0]  shadow_q, shadow_d;
  logic [9:0][W-1:0]  cur_arr;
  logic [4:0][W-1:0]  dim;

  logic [3:0]         elem_q;
  logic               div_act_q;
  logic [IW-1:0]      iter_q;
  logic [RW-1:0]      rem_q;
  logic [SW-1:0]      quo_q;
  logic [CW-1:0]      dvs_q;

  logic               elem_k;
  logic [CW-1:0]      elem_cnt;
  logic               elem_empty;
  logic [RW-1:0]      rem_sh;
  logic               rem_ge;
  logic [RW-1:0]      rem_nx;
  logic [SW-1:0]      quo_nx;
  logic               iter_last;
  logic               elem_wr;
  logic [W-1:0]       elem_val;
  logic               last_elem;

  assign cur_arr = cur_centroids;
  assign dim     = {data4, data3, data2, data1, data0};

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    elem_k     = (elem_q >= 4'd5);
    elem_cnt   = cnt_q[elem_k];
    elem_empty = (elem_cnt == '0);
    rem_sh     = {rem_q[RW-2:0], quo_q[SW-1]};
    rem_ge     = (rem_sh >= {1'b0, dvs_q});
    rem_nx     = rem_ge ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    quo_nx     = {quo_q[SW-2:0], rem_ge};
    iter_last  = div_act_q && (iter_q == IW'(SW - 1));
    elem_wr    = (state_q == DIV) && (div_act_q ? iter_last : elem_empty);
    elem_val   = div_act_q ? quo_nx[W-1:0] : cur_arr[elem_q];
    last_elem  = elem_wr && (elem_q == 4'd9);
    shadow_d   = shadow_q;
    if (elem_wr) begin
      shadow_d[elem_q] = elem_val;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACC;
        end
      end
      ACC: begin
        busy = 1'b1;
        if (in_valid && in_last) begin
          state_d = DIV;
        end
      end
      DIV: begin
        busy = 1'b1;
        if (last_elem) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are loaded on the edge that enters DONE, using the shadow value that
  // includes the final quotient, so they are valid while done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      elem_q        <= '0;
      div_act_q     <= 1'b0;
      iter_q        <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      new_centroids <= '0;
      done          <= 1'b0;
      converged     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sum_q     <= '0;
            cnt_q     <= '0;
            elem_q    <= '0;
            div_act_q <= 1'b0;
            iter_q    <= '0;
          end
        end
        ACC: begin
          if (in_valid) begin
            for (int unsigned d = 0; d < 5; d++) begin
              if (selected_centroid) begin
                sum_q[5+d] <= sum_q[5+d] + SW'(dim[d]);
              end else begin
                sum_q[d] <= sum_q[d] + SW'(dim[d]);
              end
            end
            cnt_q[selected_centroid] <= cnt_q[selected_centroid] + 1'b1;
          end
        end
        DIV: begin
          shadow_q <= shadow_d;
          if (div_act_q) begin
            rem_q  <= rem_nx;
            quo_q  <= quo_nx;
            iter_q <= iter_q + 1'b1;
            if (iter_last) begin
              div_act_q <= 1'b0;
              elem_q    <= elem_q + 4'd1;
            end
          end else if (elem_empty) begin
            elem_q <= elem_q + 4'd1;
          end else begin
            div_act_q <= 1'b1;
            iter_q    <= '0;
            rem_q     <= '0;
            quo_q     <= sum_q[elem_q];
            dvs_q     <= elem_cnt;
          end
          if (last_elem) begin
            new_centroids <= shadow_d;
            converged     <= (shadow_d == cur_arr);
            done          <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kmeans_k2n5_centroid_update.sv
// Randomized and directed bench for kmeans_k2n5_centroid_update against a
// floor-division reference model of per-cluster means.
module tb_kmeans_k2n5_centroid_update;

  localparam int W = 8;
  localparam int Q = 8;

  logic            clk = 1'b0;
  logic            rst, start, in_valid, in_last, selected_centroid;
  logic [W-1:0]    data0, data1, data2, data3, data4;
  logic [10*W-1:0] cur_centroids, new_centroids;
  logic            busy, done, converged;

  always #5 clk = ~clk;

  kmeans_k2n5_centroid_update #(
    .input_data_width(W),
    .input_data_qty_bit_width(Q)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
    .selected_centroid(selected_centroid),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3), .data4(data4),
    .cur_centroids(cur_centroids), .new_centroids(new_centroids),
    .busy(busy), .done(done), .converged(converged)
  );

  typedef struct packed {
    logic            k;
    logic [4:0][W-1:0] v;
  } samp_t;

  samp_t           sq[$];
  int              n_vec = 0;
  int              n_err = 0;
  logic [10*W-1:0] exp_new;
  logic [10*W-1:0] last_exp;
  int              exp_lat;

  task automatic chk(input string tag, input logic [10*W-1:0] obs, input logic [10*W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_samp(input logic k, input int unsigned a, b, c, d, e);
    samp_t s;
    s.k = k;
    s.v = {W'(e), W'(d), W'(c), W'(b), W'(a)};
    sq.push_back(s);
  endtask

  // Reference: per-cluster integer mean, empty cluster keeps its current value.
  task automatic model();
    int unsigned s[10];
    int unsigned c[2];
    foreach (s[i]) s[i] = 0;
    c[0] = 0;
    c[1] = 0;
    foreach (sq[j]) begin
      c[sq[j].k]++;
      for (int d = 0; d < 5; d++) s[int'(sq[j].k) * 5 + d] += sq[j].v[d];
    end
    exp_lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (c[i / 5] == 0) begin
        exp_new[i*W +: W] = cur_centroids[i*W +: W];
        exp_lat += 1;
      end else begin
        exp_new[i*W +: W] = W'(s[i] / c[i / 5]);
        exp_lat += W + Q + 1;
      end
    end
  endtask

  task automatic feed(input bit poke);
    start = 1'b1;
    step();
    start = 1'b0;
    foreach (sq[j]) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        step();
      end
      in_valid          = 1'b1;
      in_last           = (j == sq.size() - 1);
      selected_centroid = sq[j].k;
      {data4, data3, data2, data1, data0} = sq[j].v;
      start             = poke && (j == 0);
      step();
      start = 1'b0;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_pass(input string tag, input bit poke);
    int cnt;
    model();
    feed(poke);
    chk({tag, ":busy_div"}, busy, 1);
    cnt = 0;
    while (done !== 1'b1 && cnt < 2000) begin
      start = poke && (cnt == 10);
      step();
      start = 1'b0;
      cnt++;
      if (cnt == 40) chk({tag, ":hold"}, new_centroids, last_exp);
    end
    chk({tag, ":latency"}, cnt, exp_lat);
    chk({tag, ":new"}, new_centroids, exp_new);
    chk({tag, ":converged"}, converged, (exp_new == cur_centroids));
    chk({tag, ":busy_done"}, busy, 0);
    step();
    chk({tag, ":done_pulse"}, done, 0);
    chk({tag, ":conv_held"}, converged, (exp_new == cur_centroids));
    last_exp = exp_new;
    sq.delete();
  endtask

  initial begin
    bit saw;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; selected_centroid = 1'b0;
    {data4, data3, data2, data1, data0} = '0;
    cur_centroids = '0;
    last_exp = '0;
    #12;
    chk("reset:new", new_centroids, 0);
    chk("reset:flags", {busy, done, converged}, 0);
    step();
    rst = 1'b0;
    step();

    // in_valid while idle must not leak into the next pass
    in_valid = 1'b1; in_last = 1'b1; {data4, data3, data2, data1, data0} = {5{8'd200}};
    repeat (3) step();
    in_valid = 1'b0; in_last = 1'b0;
    step();

    add_samp(0, 10, 20, 30, 40, 50);
    add_samp(0, 12, 22, 32, 42, 52);
    add_samp(1, 100, 100, 100, 100, 100);
    add_samp(1, 101, 101, 101, 101, 101);
    run_pass("basic", 0);
    chk("basic:const", new_centroids, {{5{8'd100}}, 8'd51, 8'd41, 8'd31, 8'd21, 8'd11});

    cur_centroids = last_exp;
    add_samp(0, 10, 20, 30, 40, 50);
    add_samp(0, 12, 22, 32, 42, 52);
    add_samp(1, 100, 100, 100, 100, 100);
    add_samp(1, 101, 101, 101, 101, 101);
    run_pass("conv", 1);
    chk("conv:flag", converged, 1);

    cur_centroids = {{5{8'd1}}, {5{8'd0}}};
    repeat (3) add_samp(0, 6, 6, 6, 6, 6);
    run_pass("empty", 0);
    chk("empty:const", new_centroids, {{5{8'd1}}, {5{8'd6}}});

    cur_centroids = {$urandom, $urandom, 16'($urandom)};
    repeat (256) add_samp(0, 255, 255, 255, 255, 255);
    run_pass("full", 0);

    // Reset in the middle of division aborts the pass
    add_samp(0, 1, 2, 3, 4, 5);
    add_samp(1, 9, 9, 9, 9, 9);
    feed(0);
    sq.delete();
    repeat (50) step();
    #3 rst = 1'b1;
    #1;
    chk("rst_div:new", new_centroids, 0);
    chk("rst_div:flags", {busy, done, converged}, 0);
    step();
    rst = 1'b0;
    last_exp = '0;
    saw = 1'b0;
    repeat (300) begin
      step();
      if (done === 1'b1) saw = 1'b1;
    end
    chk("rst_div:no_done", saw, 0);

    for (int p = 0; p < 8; p++) begin
      int n;
      int mode;
      cur_centroids = {$urandom, $urandom, 16'($urandom)};
      n    = $urandom_range(1, 30);
      mode = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) begin
        add_samp((mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1)),
                 $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255));
      end
      run_pass($sformatf("rand%0d", p), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
